fixed_accum_dump: RTL and testbench

Integrate-and-dump stage that sits directly downstream of the fixed-point compute level. It consumes the signed fixed-point result stream (c_int format), aligns each sample to the output exponent, and accumulates NUM_SAMPLES samples with saturation. It then emits one fixed-point sum through a valid/ready handshake and clears for the next window.

---
 rtl/fixed_accum_dump.sv | 127 ++++++++++++
 tb/tb_fixed_accum_dump.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_accum_dump.sv
// Integrate-and-dump: aligns signed fixed-point samples to the output exponent, accumulates a
// window of NUM_SAMPLES with saturation, then presents the sum on a valid/ready output.
module fixed_accum_dump #(
  parameter int          IN_WIDTH     = 18,
  parameter int          IN_EXPONENT  = -10,
  parameter int          OUT_WIDTH    = 24,
  parameter int          OUT_EXPONENT = -10,
  parameter int          NUM_SAMPLES  = 16,
  localparam int         CNT_WIDTH    = $clog2(NUM_SAMPLES + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_sat,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int Shift  = IN_EXPONENT - OUT_EXPONENT;
  localparam int LShift = (Shift > 0) ? Shift : 0;
  localparam int RShift = (Shift < 0) ? -Shift : 0;
  localparam int AlW    = OUT_WIDTH + 2;
  localparam int SumW   = OUT_WIDTH + 3;
  localparam int ExtW   = IN_WIDTH + LShift;
  localparam int WideW  = ((ExtW > SumW) ? ExtW : SumW) + 1;

  localparam logic [CNT_WIDTH-1:0] LastCnt = CNT_WIDTH'(NUM_SAMPLES - 1);

  typedef enum logic {StAccum, StDump} state_e;

  state_e                       state_q, state_d;
  logic signed [OUT_WIDTH-1:0]  acc_q, acc_d;
  logic        [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                         sat_q, sat_d;
  logic        [OUT_WIDTH-1:0]  out_data_q, out_data_d;
  logic                         out_sat_q, out_sat_d;

  logic signed [WideW-1:0]      in_ext;
  logic signed [WideW-1:0]      al_wide;
  logic                         al_fits_out, al_fits_al;
  logic signed [AlW-1:0]        aligned;
  logic signed [SumW-1:0]       sum;
  logic                         sum_fits;
  logic        [OUT_WIDTH-1:0]  sum_clamped;
  logic                         clamp;

  // Alignment is done wide enough that no bits are lost before range checks.
  always_comb begin
    in_ext      = WideW'($signed(in_data));
    al_wide     = (in_ext <<< LShift) >>> RShift;
    al_fits_out = (&al_wide[WideW-1:OUT_WIDTH-1]) | ~(|al_wide[WideW-1:OUT_WIDTH-1]);
    al_fits_al  = (&al_wide[WideW-1:AlW-1]) | ~(|al_wide[WideW-1:AlW-1]);
    aligned     = al_fits_al ? al_wide[AlW-1:0]
                             : {al_wide[WideW-1], {(AlW-1){~al_wide[WideW-1]}}};
    sum         = SumW'(acc_q) + SumW'(aligned);
    sum_fits    = (&sum[SumW-1:OUT_WIDTH-1]) | ~(|sum[SumW-1:OUT_WIDTH-1]);
    sum_clamped = sum_fits ? sum[OUT_WIDTH-1:0]
                           : {sum[SumW-1], {(OUT_WIDTH-1){~sum[SumW-1]}}};
    clamp       = ~sum_fits | ~al_fits_out;
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    sat_d      = sat_q;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;
    case (state_q)
      StAccum: begin
        if (clear) begin
          acc_d = '0;
          cnt_d = '0;
          sat_d = 1'b0;
        end else if (in_valid) begin
          if (cnt_q == LastCnt) begin
            out_data_d = sum_clamped;
            out_sat_d  = sat_q | clamp;
            acc_d      = '0;
            cnt_d      = '0;
            sat_d      = 1'b0;
            state_d    = StDump;
          end else begin
            acc_d = $signed(sum_clamped);
            cnt_d = cnt_q + CNT_WIDTH'(1);
            sat_d = sat_q | clamp;
          end
        end
      end
      StDump: begin
        // Window state was already zeroed on entry; only the output is pending here.
        if (out_ready) begin
          state_d = StAccum;
        end
      end
      default: state_d = StAccum;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StAccum;
      acc_q      <= '0;
      cnt_q      <= '0;
      sat_q      <= 1'b0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      sat_q      <= sat_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
    end
  end

  assign in_ready  = (state_q == StAccum);
  assign out_valid = (state_q == StDump);
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_fixed_accum_dump.sv
// Self-checking bench: five parameterisations share one stimulus stream; directed scenarios
// plus a randomized run against an arithmetic reference model.
module tb_fixed_accum_dump;

  logic        clk = 1'b0;
  logic        rst_n, clear, in_valid, out_ready;
  logic [17:0] in_data;
  logic [4:0]  ir, ov, os;
  logic [23:0] od0, od1, od2, od4;
  logic [11:0] od3;
  logic signed [63:0] obs [5];

  int n_cmp = 0;
  int n_fail = 0;

  // Instance parameters as seen by the reference model.
  int ns_p [5] = '{4, 2, 1, 4, 16};
  int sh_p [5] = '{0, 2, -2, 0, 0};
  int ow_p [5] = '{24, 24, 24, 12, 24};

  longint m_acc [5];
  int     m_cnt [5];
  bit     m_sat [5];
  bit     m_pend [5];
  longint m_data [5];
  bit     m_osat [5];
  int     m_windows [5];

  always #5 clk = ~clk;

  fixed_accum_dump #(.NUM_SAMPLES(4)) u_a (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ir[0]), .out_data(od0), .out_sat(os[0]), .out_valid(ov[0]), .out_ready(out_ready)
  );
  fixed_accum_dump #(.IN_EXPONENT(-8), .NUM_SAMPLES(2)) u_shl (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ir[1]), .out_data(od1), .out_sat(os[1]), .out_valid(ov[1]), .out_ready(out_ready)
  );
  fixed_accum_dump #(.OUT_EXPONENT(-8), .NUM_SAMPLES(1)) u_shr (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ir[2]), .out_data(od2), .out_sat(os[2]), .out_valid(ov[2]), .out_ready(out_ready)
  );
  fixed_accum_dump #(.OUT_WIDTH(12), .NUM_SAMPLES(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ir[3]), .out_data(od3), .out_sat(os[3]), .out_valid(ov[3]), .out_ready(out_ready)
  );
  fixed_accum_dump #(.NUM_SAMPLES(16)) u_rnd (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ir[4]), .out_data(od4), .out_sat(os[4]), .out_valid(ov[4]), .out_ready(out_ready)
  );

  assign obs[0] = 64'($signed(od0));
  assign obs[1] = 64'($signed(od1));
  assign obs[2] = 64'($signed(od2));
  assign obs[3] = 64'($signed(od3));
  assign obs[4] = 64'($signed(od4));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    tick; tick;
    rst_n = 1'b1;
  endtask

  // Feed one sample per cycle; out_valid must stay low until the last one is accepted.
  task automatic feed(input int idx, input int val, input int n, input string name);
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b1; in_data = 18'(val);
      tick;
      if (k < n - 1) begin
        n_cmp++;
        if (ov[idx] !== 1'b0) begin
          n_fail++; $display("FAIL %s_early_valid k=%0d got %b want 0", name, k, ov[idx]);
        end
      end
    end
    in_valid = 1'b0;
  endtask

  function automatic longint align_val(input longint v, input int sh);
    longint d, q;
    if (sh >= 0) return v * (longint'(1) << sh);
    d = longint'(1) << (-sh);
    q = v / d;
    if (v < 0 && q * d != v) q = q - 1;
    return q;
  endfunction

  task automatic model_reset;
    for (int i = 0; i < 5; i++) begin
      m_acc[i] = 0; m_cnt[i] = 0; m_sat[i] = 0; m_pend[i] = 0;
      m_data[i] = 0; m_osat[i] = 0; m_windows[i] = 0;
    end
  endtask

  // Advance every model by one clock edge given the inputs currently driven.
  task automatic model_step;
    longint lo, hi, al, s;
    bit c;
    for (int i = 0; i < 5; i++) begin
      if (!rst_n) begin
        m_acc[i] = 0; m_cnt[i] = 0; m_sat[i] = 0; m_pend[i] = 0;
      end else if (m_pend[i]) begin
        if (out_ready) m_pend[i] = 0;
      end else if (clear) begin
        m_acc[i] = 0; m_cnt[i] = 0; m_sat[i] = 0;
      end else if (in_valid) begin
        lo = -(longint'(1) << (ow_p[i] - 1));
        hi = -lo - 1;
        al = align_val(longint'($signed(in_data)), sh_p[i]);
        s  = m_acc[i] + al;
        c  = (al < lo) || (al > hi) || (s < lo) || (s > hi);
        if (s < lo) s = lo;
        if (s > hi) s = hi;
        if (m_cnt[i] == ns_p[i] - 1) begin
          m_data[i] = s; m_osat[i] = m_sat[i] | c; m_pend[i] = 1;
          m_acc[i] = 0; m_cnt[i] = 0; m_sat[i] = 0;
          m_windows[i]++;
        end else begin
          m_acc[i] = s; m_cnt[i]++; m_sat[i] = m_sat[i] | c;
        end
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b1; in_data = 18'd5; out_ready = 1'b0;
    tick;
    n_cmp++; if (ov !== 5'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", ov); end
    n_cmp++; if (ir !== 5'h1f) begin n_fail++; $display("FAIL reset_ready got %b want 11111", ir); end
    n_cmp++; if (obs[0] !== 64'sd0) begin n_fail++; $display("FAIL reset_data got %0d want 0", obs[0]); end
    n_cmp++; if (os !== 5'b0) begin n_fail++; $display("FAIL reset_sat got %b want 0", os); end
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    tick;
    n_cmp++; if (ir !== 5'h1f) begin n_fail++; $display("FAIL release_ready got %b want 11111", ir); end
  endtask

  task automatic test_basic;
    do_reset;
    feed(0, 1024, 4, "basic");
    n_cmp++; if (ov[0] !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %b want 1", ov[0]); end
    n_cmp++; if (obs[0] !== 64'sd4096) begin n_fail++; $display("FAIL basic_data got %0d want 4096", obs[0]); end
    n_cmp++; if (os[0] !== 1'b0) begin n_fail++; $display("FAIL basic_sat got %b want 0", os[0]); end
    n_cmp++; if (ir[0] !== 1'b0) begin n_fail++; $display("FAIL basic_dump_ready got %b want 0", ir[0]); end
    tick;
    n_cmp++; if (ov[0] !== 1'b0) begin n_fail++; $display("FAIL basic_one_cycle got %b want 0", ov[0]); end
    n_cmp++; if (ir[0] !== 1'b1) begin n_fail++; $display("FAIL basic_ready_back got %b want 1", ir[0]); end
  endtask

  task automatic test_align;
    do_reset;
    feed(1, 256, 1, "shl");
    feed(1, -128, 1, "shl");
    n_cmp++; if (ov[1] !== 1'b1) begin n_fail++; $display("FAIL shl_valid got %b want 1", ov[1]); end
    n_cmp++; if (obs[1] !== 64'sd512) begin n_fail++; $display("FAIL shl_data got %0d want 512", obs[1]); end
    do_reset;
    feed(2, -1, 1, "shr");
    n_cmp++; if (ov[2] !== 1'b1) begin n_fail++; $display("FAIL shr_valid got %b want 1", ov[2]); end
    n_cmp++; if (obs[2] !== -64'sd1) begin n_fail++; $display("FAIL shr_floor got %0d want -1", obs[2]); end
    tick;
    n_cmp++; if (ov[2] !== 1'b0) begin n_fail++; $display("FAIL shr_handshake got %b want 0", ov[2]); end
    feed(2, 3, 1, "shr");
    n_cmp++; if (obs[2] !== 64'sd0 || ov[2] !== 1'b1) begin
      n_fail++; $display("FAIL shr_trunc got %0d/%b want 0/1", obs[2], ov[2]);
    end
  endtask

  task automatic test_saturation;
    do_reset;
    feed(3, 1024, 4, "sat");
    n_cmp++; if (obs[3] !== 64'sd2047) begin n_fail++; $display("FAIL sat_data got %0d want 2047", obs[3]); end
    n_cmp++; if (os[3] !== 1'b1) begin n_fail++; $display("FAIL sat_flag got %b want 1", os[3]); end
    tick;
    for (int v = 1; v <= 4; v++) feed(3, v, 1, "sat2");
    n_cmp++; if (ov[3] !== 1'b1) begin n_fail++; $display("FAIL sat2_valid got %b want 1", ov[3]); end
    n_cmp++; if (obs[3] !== 64'sd10) begin n_fail++; $display("FAIL sat2_data got %0d want 10", obs[3]); end
    n_cmp++; if (os[3] !== 1'b0) begin n_fail++; $display("FAIL sat2_flag got %b want 0", os[3]); end
  endtask

  task automatic test_backpressure;
    do_reset;
    out_ready = 1'b0;
    feed(0, 100, 4, "bp");
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_data = 18'd7;
      tick;
      n_cmp++; if (ov[0] !== 1'b1 || obs[0] !== 64'sd400 || os[0] !== 1'b0 || ir[0] !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold k=%0d got v=%b d=%0d s=%b r=%b want 1/400/0/0",
                           k, ov[0], obs[0], os[0], ir[0]);
      end
    end
    out_ready = 1'b1;
    tick;
    n_cmp++; if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
      n_fail++; $display("FAIL bp_release got v=%b r=%b want 0/1", ov[0], ir[0]);
    end
    feed(0, 5, 4, "bp_next");
    n_cmp++; if (ov[0] !== 1'b1 || obs[0] !== 64'sd20) begin
      n_fail++; $display("FAIL bp_next got v=%b d=%0d want 1/20", ov[0], obs[0]);
    end
  endtask

  task automatic test_clear;
    do_reset;
    feed(0, 50, 2, "clr");
    clear = 1'b1; in_valid = 1'b1; in_data = 18'd999;
    tick;
    clear = 1'b0;
    n_cmp++; if (ov[0] !== 1'b0) begin n_fail++; $display("FAIL clr_no_dump got %b want 0", ov[0]); end
    feed(0, 100, 4, "clr_win");
    n_cmp++; if (ov[0] !== 1'b1 || obs[0] !== 64'sd400 || os[0] !== 1'b0) begin
      n_fail++; $display("FAIL clr_data got v=%b d=%0d s=%b want 1/400/0", ov[0], obs[0], os[0]);
    end
  endtask

  task automatic test_reset_in_dump;
    do_reset;
    out_ready = 1'b0;
    feed(0, 9, 4, "rd");
    n_cmp++; if (ov[0] !== 1'b1 || obs[0] !== 64'sd36) begin
      n_fail++; $display("FAIL rd_pending got v=%b d=%0d want 1/36", ov[0], obs[0]);
    end
    rst_n = 1'b0;
    tick;
    n_cmp++; if (ov[0] !== 1'b0 || obs[0] !== 64'sd0 || ir[0] !== 1'b1) begin
      n_fail++; $display("FAIL rd_lost got v=%b d=%0d r=%b want 0/0/1", ov[0], obs[0], ir[0]);
    end
    rst_n = 1'b1;
    tick;
    n_cmp++; if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
      n_fail++; $display("FAIL rd_after got v=%b r=%b want 0/1", ov[0], ir[0]);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_random;
    int cyc;
    do_reset;
    model_reset;
    cyc = 0;
    while (m_windows[4] < 1000 && cyc < 80000) begin
      rst_n     = ($urandom_range(0, 4999) != 0);
      clear     = ($urandom_range(0, 199) == 0);
      in_valid  = ($urandom_range(0, 9) < 8);
      out_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 1) == 1) in_data = 18'($urandom);
      else in_data = 18'(int'($urandom_range(0, 4095)) - 2048);
      model_step;
      tick;
      cyc++;
      for (int i = 0; i < 5; i++) begin
        n_cmp++;
        if (ov[i] !== m_pend[i] || ir[i] !== !m_pend[i]) begin
          n_fail++; $display("FAIL rnd_hs inst=%0d cyc=%0d got v=%b r=%b want v=%b", i, cyc,
                             ov[i], ir[i], m_pend[i]);
        end
        if (m_pend[i]) begin
          n_cmp++;
          if (obs[i] !== m_data[i] || os[i] !== m_osat[i]) begin
            n_fail++; $display("FAIL rnd_data inst=%0d cyc=%0d got %0d/%b want %0d/%b", i, cyc,
                               obs[i], os[i], m_data[i], m_osat[i]);
          end
        end
      end
    end
    rst_n = 1'b1; clear = 1'b0; in_valid = 1'b0;
    n_cmp++;
    if (m_windows[4] < 1000) begin
      n_fail++; $display("FAIL rnd_budget got %0d windows want 1000", m_windows[4]);
    end
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    test_reset;
    test_basic;
    test_align;
    test_saturation;
    test_backpressure;
    test_clear;
    test_reset_in_dump;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
